// File: rtl/logic_pipe_pkg.sv
// Shared operation encodings and default geometry for logic_pipe_unit.
package logic_pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;
    localparam int unsigned DEFAULT_DEPTH = 7;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NOR    = 3'b011,
        OP_NAND   = 3'b100,
        OP_XNOR   = 3'b101,
        OP_PASS_A = 3'b110,
        OP_NOT_A  = 3'b111
    } op_e;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus op and both operands, loaded on demand, cleared synchronously.
module pipe_stage
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             in_valid,
    input  op_e              in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output op_e              out_op,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);

    logic             valid_q, valid_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Payload only moves with a valid beat so bubbles do not toggle the data flops.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                op_d = in_op;
                a_d  = in_a;
                b_d  = in_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_a     = a_q;
    assign out_b     = b_q;

endmodule

// File: rtl/logic_pipe_unit.sv
// Bitwise logic unit behind a DEPTH-stage elastic pipeline; the function is evaluated on the last stage.
module logic_pipe_unit
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             busy
);

    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_ready;
    op_e              stg_op [DEPTH];
    logic [WIDTH-1:0] stg_a  [DEPTH];
    logic [WIDTH-1:0] stg_b  [DEPTH];
    logic             clear;
    logic             in_fire;
    logic [WIDTH-1:0] result;

    assign clear    = rst || flush;
    assign in_ready = stg_ready[0] && !flush;
    assign in_fire  = in_valid && in_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        op_e              up_op;
        logic [WIDTH-1:0] up_a;
        logic [WIDTH-1:0] up_b;

        // A slot can move iff some slot at or after it is empty or the tail drains;
        // written as a direct reduction instead of a ripple chain.
        assign stg_ready[k] = out_ready || !(&stg_valid[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign up_valid = in_fire;
            assign up_op    = op_e'(op);
            assign up_a     = a;
            assign up_b     = b;
        end else begin : g_body
            assign up_valid = stg_valid[k-1];
            assign up_op    = stg_op[k-1];
            assign up_a     = stg_a[k-1];
            assign up_b     = stg_b[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .clear     (clear),
            .load      (stg_ready[k]),
            .in_valid  (up_valid),
            .in_op     (up_op),
            .in_a      (up_a),
            .in_b      (up_b),
            .out_valid (stg_valid[k]),
            .out_op    (stg_op[k]),
            .out_a     (stg_a[k]),
            .out_b     (stg_b[k])
        );
    end

    always_comb begin
        result = '0;
        case (stg_op[DEPTH-1])
            OP_AND:    result = stg_a[DEPTH-1] & stg_b[DEPTH-1];
            OP_OR:     result = stg_a[DEPTH-1] | stg_b[DEPTH-1];
            OP_XOR:    result = stg_a[DEPTH-1] ^ stg_b[DEPTH-1];
            OP_NOR:    result = ~(stg_a[DEPTH-1] | stg_b[DEPTH-1]);
            OP_NAND:   result = ~(stg_a[DEPTH-1] & stg_b[DEPTH-1]);
            OP_XNOR:   result = ~(stg_a[DEPTH-1] ^ stg_b[DEPTH-1]);
            OP_PASS_A: result = stg_a[DEPTH-1];
            OP_NOT_A:  result = ~stg_a[DEPTH-1];
        endcase
    end

    assign out_valid = stg_valid[DEPTH-1];
    assign out       = result;
    assign out_zero  = out_valid && (result == '0);
    assign busy      = |stg_valid;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Self-checking bench for logic_pipe_unit: a 64x7 instance and an 8x1 instance against a queue model.
module tb_logic_pipe_unit;

    localparam int W0 = 64;
    localparam int D0 = 7;
    localparam int W1 = 8;
    localparam int D1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready, in_ready, out_valid, out_zero, busy;
    logic [2:0]    op;
    logic [W0-1:0] a, b, out;

    logic          rst1, flush1, in_valid1, out_ready1, in_ready1, out_valid1, out_zero1, busy1;
    logic [2:0]    op1;
    logic [W1-1:0] a1, b1, out1;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Model: items in flight in acceptance order, each tagged with its acceptance cycle.
    // The oldest item is presented once DEPTH cycles have elapsed since it was accepted.
    logic [W0-1:0] mq_res[$];
    longint        mq_t[$];
    logic          e_in_ready, e_out_valid, e_out_zero, e_busy;
    logic [W0-1:0] e_out;

    logic_pipe_unit #(.WIDTH(W0), .DEPTH(D0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_zero(out_zero), .busy(busy)
    );

    logic_pipe_unit #(.WIDTH(W1), .DEPTH(D1)) dut1 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out(out1), .out_zero(out_zero1), .busy(busy1)
    );

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x | y);
            3'd4:    return ~(x & y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    task automatic eval0();
        e_busy      = (mq_res.size() != 0);
        e_out_valid = e_busy && ((cyc - mq_t[0]) >= D0);
        e_out       = e_busy ? mq_res[0] : '0;
        e_out_zero  = e_out_valid && (e_out == '0);
        e_in_ready  = !flush && ((mq_res.size() < D0) || out_ready);
    endtask

    task automatic step0();
        eval0();
        if (e_out_valid && out_ready) begin
            void'(mq_res.pop_front());
            void'(mq_t.pop_front());
        end
        if (in_valid && e_in_ready) begin
            mq_res.push_back(ref_op(op, a, b));
            mq_t.push_back(cyc);
        end
        if (rst || flush) begin
            mq_res.delete();
            mq_t.delete();
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        step0();
        step0();
        rst = 1'b0; rst1 = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b exp 0", out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset1_out_valid: got %b exp 0", out_valid1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset1_busy: got %b exp 0", busy1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset1_in_ready: got %b exp 1", in_ready1); end
    endtask

    task automatic test_single();
        out_ready = 1'b1; op = 3'b001;
        a = 64'h1111111111111111; b = 64'h1111111111111111;
        for (int k = 0; k <= 10; k++) begin
            in_valid = (k == 0);
            #1; eval0();
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL single_valid_model k=%0d: got %b exp %b", k, out_valid, e_out_valid); end
            checks++; if (out_valid !== (k == D0)) begin errors++; $display("FAIL single_valid_cycle k=%0d: got %b exp %b", k, out_valid, (k == D0)); end
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("FAIL single_in_ready k=%0d: got %b exp %b", k, in_ready, e_in_ready); end
            if (out_valid === 1'b1) begin
                checks++; if (out !== 64'h1111111111111111) begin errors++; $display("FAIL single_out: got %h exp 1111111111111111", out); end
            end
            step0();
        end
    endtask

    task automatic test_back_to_back();
        logic [W0-1:0] got[$];
        int            first_k, last_k;
        first_k = -1; last_k = -1;
        a = 64'hFF00FF00FF00FF00; b = 64'h0F0F0F0F0F0F0F0F; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 8); op = 3'(k);
            #1; eval0();
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL b2b_valid k=%0d: got %b exp %b", k, out_valid, e_out_valid); end
            checks++; if (out_zero !== e_out_zero) begin errors++; $display("FAIL b2b_zero k=%0d: got %b exp %b", k, out_zero, e_out_zero); end
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("FAIL b2b_in_ready k=%0d: got %b exp %b", k, in_ready, e_in_ready); end
            if (out_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                got.push_back(out);
            end
            step0();
        end
        in_valid = 1'b0;
        checks++; if (got.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d exp 8", got.size()); end
        checks++; if (last_k - first_k != 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d exp 7", last_k - first_k); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] !== ref_op(3'(i), 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F)) begin
                errors++; $display("FAIL b2b_result op=%0d: got %h exp %h", i, got[i], ref_op(3'(i), 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F));
            end
        end
        if (got.size() >= 4) begin
            checks++; if (got[0] !== 64'h0F000F000F000F00) begin errors++; $display("FAIL b2b_and: got %h exp 0F000F000F000F00", got[0]); end
            checks++; if (got[3] !== 64'h00F000F000F000F0) begin errors++; $display("FAIL b2b_nor: got %h exp 00F000F000F000F0", got[3]); end
        end
    endtask

    task automatic test_backpressure();
        int            acc, drained;
        logic          have_held;
        logic [W0-1:0] held;
        acc = 0; drained = 0; have_held = 1'b0; held = '0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            op = 3'($urandom_range(0, 7)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            #1; eval0();
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("FAIL bp_in_ready k=%0d: got %b exp %b", k, in_ready, e_in_ready); end
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL bp_valid k=%0d: got %b exp %b", k, out_valid, e_out_valid); end
            if (in_ready === 1'b1) acc++;
            if (out_valid === 1'b1) begin
                if (!have_held) begin
                    held = out; have_held = 1'b1;
                    checks++; if (out !== e_out) begin errors++; $display("FAIL bp_head: got %h exp %h", out, e_out); end
                end else begin
                    checks++; if (out !== held) begin errors++; $display("FAIL bp_stable k=%0d: got %h exp %h", k, out, held); end
                end
            end
            step0();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (acc != D0) begin errors++; $display("FAIL bp_accepted: got %0d exp %0d", acc, D0); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b exp 0", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1; eval0();
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL drain_valid k=%0d: got %b exp %b", k, out_valid, e_out_valid); end
            if (e_out_valid) begin
                checks++; if (out !== e_out) begin errors++; $display("FAIL drain_out k=%0d: got %h exp %h", k, out, e_out); end
            end
            if (out_valid === 1'b1) drained++;
            step0();
        end
        checks++; if (drained != D0) begin errors++; $display("FAIL drain_count: got %0d exp %0d", drained, D0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b exp 0", busy); end
    endtask

    task automatic test_flush();
        int leaked;
        leaked = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = 3'($urandom_range(0, 7)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            #1; eval0();
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("FAIL flush_fill_ready k=%0d: got %b exp %b", k, in_ready, e_in_ready); end
            step0();
        end
        flush = 1'b1;
        #1; eval0();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
        checks++; if (busy !== e_busy) begin errors++; $display("FAIL flush_busy_before: got %b exp %b", busy, e_busy); end
        step0();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b exp 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_after: got %b exp 0", out_valid); end
        for (int k = 0; k < 12; k++) begin
            #1;
            if (out_valid !== 1'b0) leaked++;
            step0();
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL flush_leak: got %0d results exp 0", leaked); end
    endtask

    task automatic test_rst_flush();
        logic seen;
        seen = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            op = 3'($urandom_range(0, 7)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            #1; eval0();
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL rf_valid k=%0d: got %b exp %b", k, out_valid, e_out_valid); end
            if (e_out_valid) begin
                checks++; if (out !== e_out) begin errors++; $display("FAIL rf_out k=%0d: got %h exp %h", k, out, e_out); end
            end
            step0();
        end
        rst = 1'b1; flush = 1'b1;
        step0();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid: got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rf_busy: got %b exp 0", busy); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL rf_out_zero: got %b exp 0", out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready: got %b exp 1", in_ready); end
        op = 3'b010; a = {$urandom, $urandom}; b = a; in_valid = 1'b1;
        step0();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++; if (out !== '0) begin errors++; $display("FAIL xor_out: got %h exp 0", out); end
                checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL xor_zero: got %b exp 1", out_zero); end
            end
            step0();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL xor_timeout: got no result exp one"); end
    endtask

    task automatic test_random_depth1();
        logic [W1-1:0] q_res[$];
        longint        q_t[$];
        logic [63:0]   full;
        logic [W1-1:0] head;
        logic          ev, er;
        int            n_in, n_out;
        n_in = 0; n_out = 0;
        for (int k = 0; k < 1000; k++) begin
            in_valid1 = 1'($urandom_range(0, 1)); out_ready1 = ($urandom_range(0, 3) != 0);
            op1 = 3'($urandom_range(0, 7)); a1 = W1'($urandom); b1 = W1'($urandom);
            #1;
            head = (q_res.size() != 0) ? q_res[0] : '0;
            ev   = (q_res.size() != 0) && ((cyc - q_t[0]) >= D1);
            er   = (q_res.size() < D1) || out_ready1;
            checks++; if (in_ready1 !== er) begin errors++; $display("FAIL rnd_in_ready k=%0d: got %b exp %b", k, in_ready1, er); end
            checks++; if (out_valid1 !== ev) begin errors++; $display("FAIL rnd_valid k=%0d: got %b exp %b", k, out_valid1, ev); end
            checks++; if (busy1 !== (q_res.size() != 0)) begin errors++; $display("FAIL rnd_busy k=%0d: got %b exp %b", k, busy1, (q_res.size() != 0)); end
            checks++; if (out_zero1 !== (ev && head == '0)) begin errors++; $display("FAIL rnd_zero k=%0d: got %b exp %b", k, out_zero1, (ev && head == '0)); end
            if (ev) begin
                checks++; if (out1 !== head) begin errors++; $display("FAIL rnd_out k=%0d: got %h exp %h", k, out1, head); end
            end
            if (ev && out_ready1) begin
                void'(q_res.pop_front()); void'(q_t.pop_front()); n_out++;
            end
            if (in_valid1 && er) begin
                full = ref_op(op1, 64'(a1), 64'(b1));
                q_res.push_back(full[W1-1:0]); q_t.push_back(cyc); n_in++;
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        in_valid1 = 1'b0;
        checks++; if (n_out < 100) begin errors++; $display("FAIL rnd_traffic: got %0d outputs exp at least 100", n_out); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        rst1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_rst_flush();
        test_random_depth1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
